// File: rtl/collision_detector_if.sv
// collision_detector_if
//   Bundles the game-control, frame-timing, obstacle-pixel and cursor inputs
//   of the collision detector together with its life/status outputs.
//   Signals:
//     game_on, menu_on        game start / return-to-menu requests (level)
//     vblnk_in                vertical blanking, aligned with obstacle_x/y
//     obstacle_x, obstacle_y  obstacle pixel drawn this cycle ((0,0) = none)
//     mouse_xpos, mouse_ypos  cursor top-left position
//     lives                   remaining lives
//     hit_pulse               one-cycle strobe per accepted hit
//     invulnerable            high during post-hit cooldown
//     game_over               high once all lives are gone
//   Modports: master drives the inputs and observes the status (game side),
//             slave is the collision detector itself.
interface collision_detector_if;
  logic        game_on;
  logic        menu_on;
  logic        vblnk_in;
  logic [11:0] obstacle_x;
  logic [11:0] obstacle_y;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [3:0]  lives;
  logic        hit_pulse;
  logic        invulnerable;
  logic        game_over;

  modport master (
    output game_on, menu_on, vblnk_in, obstacle_x, obstacle_y,
           mouse_xpos, mouse_ypos,
    input  lives, hit_pulse, invulnerable, game_over
  );

  modport slave (
    input  game_on, menu_on, vblnk_in, obstacle_x, obstacle_y,
           mouse_xpos, mouse_ypos,
    output lives, hit_pulse, invulnerable, game_over
  );
endinterface

// File: rtl/collision_detector.sv
// collision_detector
//   Watches the obstacle pixels drawn each frame and decides, once per frame,
//   whether the cursor hitbox overlapped any of them. Owns the life counter,
//   the post-hit invulnerability window and the game-over flag.
//   Ports:
//     pclk  pixel clock, all state changes on the rising edge
//     rst   asynchronous, active-low reset
//     bus   collision_detector_if.slave (inputs and status outputs)
//   All outputs are registered.
module collision_detector #(
  parameter int LIVES           = 3,
  parameter int HITBOX_W        = 12,
  parameter int HITBOX_H        = 16,
  parameter int COOLDOWN_FRAMES = 60
) (
  input  logic                  pclk,
  input  logic                  rst,
  collision_detector_if.slave   bus
);

  localparam int DATA_W = 12;

  typedef enum logic [1:0] {IDLE, PLAY, COOLDOWN, OVER} state_t;

  state_t            state, state_nxt;
  logic              vblnk_d;
  logic [DATA_W-1:0] mx, my;
  logic              hit_flag, hit_flag_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [3:0]        lives_q, lives_nxt;
  logic              hit_pulse_q, hit_pulse_nxt;
  logic              invulnerable_q, invulnerable_nxt;
  logic              game_over_q, game_over_nxt;

  logic              frame_end;
  logic              pix_hit;
  logic              counted;

  // Hitbox test. Upper bounds are formed in 13 bits so a cursor near the
  // right/bottom edge cannot wrap its hitbox back to small coordinates.
  function automatic logic in_box(input logic [DATA_W-1:0] ox,
                                  input logic [DATA_W-1:0] oy,
                                  input logic [DATA_W-1:0] x0,
                                  input logic [DATA_W-1:0] y0);
    logic [DATA_W:0] x_end;
    logic [DATA_W:0] y_end;
    logic            is_pixel;
    x_end    = {1'b0, x0} + (DATA_W+1)'(HITBOX_W);
    y_end    = {1'b0, y0} + (DATA_W+1)'(HITBOX_H);
    is_pixel = (ox != '0) || (oy != '0);
    return is_pixel && (ox >= x0) && ({1'b0, ox} < x_end)
                    && (oy >= y0) && ({1'b0, oy} < y_end);
  endfunction

  assign frame_end = bus.vblnk_in & ~vblnk_d;
  assign pix_hit   = in_box(bus.obstacle_x, bus.obstacle_y, mx, my);
  // The frame-end cycle's own pixel still counts toward this frame.
  assign counted   = hit_flag | pix_hit;

  // State register
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; menu_on overrides everything else.
  always_comb begin
    state_nxt = state;
    if (bus.menu_on) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.game_on) state_nxt = PLAY;
        PLAY:     if (frame_end && counted)
                    state_nxt = (lives_q == 4'd1) ? OVER : COOLDOWN;
        COOLDOWN: if (frame_end && (cnt <= 8'd1)) state_nxt = PLAY;
        OVER:     state_nxt = OVER;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // Output / bookkeeping logic, registered below
  always_comb begin
    lives_nxt     = lives_q;
    cnt_nxt       = cnt;
    hit_flag_nxt  = 1'b0;
    hit_pulse_nxt = 1'b0;
    if (bus.menu_on) begin
      lives_nxt = 4'(LIVES);
      cnt_nxt   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          lives_nxt = 4'(LIVES);
          cnt_nxt   = 8'd0;
        end
        PLAY: begin
          if (frame_end) begin
            // One life per frame at most: the sticky flag collapses all
            // hitting pixels of the frame into a single event.
            if (counted) begin
              hit_pulse_nxt = 1'b1;
              lives_nxt     = lives_q - 4'd1;
              if (lives_q != 4'd1) cnt_nxt = 8'(COOLDOWN_FRAMES);
            end
          end else begin
            hit_flag_nxt = counted;
          end
        end
        COOLDOWN: if (frame_end) cnt_nxt = cnt - 8'd1;
        OVER:     lives_nxt = 4'd0;
        default:  lives_nxt = lives_q;
      endcase
    end
    invulnerable_nxt = (state_nxt == COOLDOWN);
    game_over_nxt    = (state_nxt == OVER);
  end

  // Registered outputs and frame bookkeeping
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      vblnk_d        <= 1'b0;
      mx             <= '0;
      my             <= '0;
      hit_flag       <= 1'b0;
      cnt            <= 8'd0;
      lives_q        <= 4'(LIVES);
      hit_pulse_q    <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      vblnk_d        <= bus.vblnk_in;
      // Cursor is frozen per frame so the whole frame tests one hitbox.
      if (frame_end) begin
        mx <= bus.mouse_xpos;
        my <= bus.mouse_ypos;
      end
      hit_flag       <= hit_flag_nxt;
      cnt            <= cnt_nxt;
      lives_q        <= lives_nxt;
      hit_pulse_q    <= hit_pulse_nxt;
      invulnerable_q <= invulnerable_nxt;
      game_over_q    <= game_over_nxt;
    end
  end

  assign bus.lives        = lives_q;
  assign bus.hit_pulse    = hit_pulse_q;
  assign bus.invulnerable = invulnerable_q;
  assign bus.game_over    = game_over_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb_collision_detector
//   Directed bench for collision_detector with LIVES=3, a 12x16 hitbox and a
//   two-frame cooldown. Expected values are hand-computed constants.
module tb_collision_detector;

  logic pclk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  collision_detector_if bus();

  collision_detector #(
    .LIVES(3),
    .HITBOX_W(12),
    .HITBOX_H(16),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .bus(bus)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int lv, input int hp, input int inv, input int go);
    chk($sformatf("%s.lives", tag),        32'(bus.lives),        32'(lv));
    chk($sformatf("%s.hit_pulse", tag),    32'(bus.hit_pulse),    32'(hp));
    chk($sformatf("%s.invulnerable", tag), 32'(bus.invulnerable), 32'(inv));
    chk($sformatf("%s.game_over", tag),    32'(bus.game_over),    32'(go));
  endtask

  task automatic pix(input int x, input int y);
    bus.obstacle_x = 12'(x);
    bus.obstacle_y = 12'(y);
    tick();
    bus.obstacle_x = 12'd0;
    bus.obstacle_y = 12'd0;
  endtask

  task automatic frame_end_edge();
    bus.vblnk_in = 1'b1;
    tick();
  endtask

  task automatic vblnk_low();
    bus.vblnk_in = 1'b0;
    tick();
  endtask

  initial begin
    rst            = 1'b0;
    bus.game_on    = 1'b0;
    bus.menu_on    = 1'b0;
    bus.vblnk_in   = 1'b0;
    bus.obstacle_x = 12'd0;
    bus.obstacle_y = 12'd0;
    bus.mouse_xpos = 12'd0;
    bus.mouse_ypos = 12'd0;
    #12;
    chk_out("reset", 3, 0, 0, 0);
    chk("reset.mx", 32'(dut.mx), 32'd0);
    chk("reset.my", 32'(dut.my), 32'd0);
    tick();
    rst = 1'b1;
    tick();

    bus.game_on = 1'b1;
    tick();
    bus.game_on = 1'b0;

    // Pixel (0,0) with cursor at (0,0); cursor (100,100) latched here
    bus.mouse_xpos = 12'd100;
    bus.mouse_ypos = 12'd100;
    frame_end_edge();
    chk_out("origin", 3, 0, 0, 0);
    chk("latch.mx", 32'(dut.mx), 32'd100);
    chk("latch.my", 32'(dut.my), 32'd100);
    vblnk_low();

    // Just outside every hitbox edge
    pix(112, 100);
    pix(100, 116);
    pix(99, 105);
    pix(105, 99);
    frame_end_edge();
    chk_out("edge_miss", 3, 0, 0, 0);
    vblnk_low();
    chk_out("edge_miss_after", 3, 0, 0, 0);

    // First counted hit
    pix(105, 110);
    tick();
    frame_end_edge();
    chk_out("hit1", 2, 1, 1, 0);
    vblnk_low();
    chk("hit1.pulse_len", 32'(bus.hit_pulse), 32'd0);

    // Cooldown frames ignore hits
    pix(111, 115);
    frame_end_edge();
    chk_out("cool2", 2, 0, 1, 0);
    vblnk_low();
    pix(111, 115);
    frame_end_edge();
    chk_out("cool3", 2, 0, 0, 0);
    vblnk_low();

    // Corner pixel hit, several hitting pixels still cost one life
    pix(111, 115);
    pix(105, 110);
    pix(100, 100);
    frame_end_edge();
    chk_out("hit2", 1, 1, 1, 0);
    vblnk_low();

    // vblnk held high: a single frame end only
    frame_end_edge();
    tick();
    tick();
    chk_out("held", 1, 0, 1, 0);
    vblnk_low();
    frame_end_edge();
    chk_out("cool6", 1, 0, 0, 0);
    vblnk_low();

    // Pixel arriving on the frame-end edge itself is fatal hit
    bus.obstacle_x = 12'd111;
    bus.obstacle_y = 12'd100;
    bus.vblnk_in   = 1'b1;
    tick();
    bus.obstacle_x = 12'd0;
    bus.obstacle_y = 12'd0;
    chk_out("hit3", 0, 1, 0, 1);
    vblnk_low();

    // OVER ignores hits
    pix(105, 110);
    frame_end_edge();
    chk_out("over", 0, 0, 0, 1);
    vblnk_low();

    bus.menu_on = 1'b1;
    tick();
    chk_out("menu", 3, 0, 0, 0);
    bus.menu_on = 1'b0;

    // menu_on wins over a hit at frame end
    bus.game_on = 1'b1;
    tick();
    bus.game_on = 1'b0;
    pix(105, 110);
    bus.menu_on  = 1'b1;
    bus.vblnk_in = 1'b1;
    tick();
    chk_out("menu_hit", 3, 0, 0, 0);
    bus.menu_on = 1'b0;
    vblnk_low();
    chk_out("menu_after", 3, 0, 0, 0);

    // Async reset in COOLDOWN, with hit_pulse still high
    bus.game_on = 1'b1;
    tick();
    bus.game_on = 1'b0;
    pix(105, 110);
    frame_end_edge();
    chk_out("hit4", 2, 1, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_out("async", 3, 0, 0, 0);
    chk("async.mx", 32'(dut.mx), 32'd0);
    bus.vblnk_in = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/collision_detector.md
# collision_detector

Consumes the per-pixel obstacle coordinates emitted by the obstacle drawing stages and the mouse cursor position, and decides once per frame whether the cursor hitbox overlapped any drawn obstacle pixel. It sits directly downstream of the obstacle stages, outside the RGB pipeline. It owns the player's life counter, post-hit invulnerability window and game-over flag, which feed the menu/game control logic and HUD.

## Interface
Parameters:
- LIVES, 3 — lives loaded on reset and on return to idle; 1..15.
- HITBOX_W, 12 — cursor hitbox width in pixels; 1..255.
- HITBOX_H, 16 — cursor hitbox height in pixels; 1..255.
- COOLDOWN_FRAMES, 60 — frames of invulnerability after a non-fatal hit; 1..255.

Ports (one clock; reset is asynchronous and active-low):
- pclk  in  1  pixel clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- game_on  in  1  game start request (level).
- menu_on  in  1  return-to-menu request (level).
- vblnk_in  in  1  vertical blanking, aligned with obstacle_x/obstacle_y.
- obstacle_x  in  12  x of obstacle pixel drawn this cycle; 0 with obstacle_y = 0 means none.
- obstacle_y  in  12  y of obstacle pixel drawn this cycle.
- mouse_xpos  in  12  cursor top-left x.
- mouse_ypos  in  12  cursor top-left y.
- lives  out  4  remaining lives.
- hit_pulse  out  1  one-cycle strobe on each accepted hit.
- invulnerable  out  1  high during cooldown.
- game_over  out  1  high in OVER state.

## Operation
- States: IDLE, PLAY, COOLDOWN, OVER.
- IDLE: lives = LIVES, cooldown counter = 0, hit flag cleared. Exits to PLAY when game_on = 1 and menu_on = 0.
- Frame end: the rising edge of vblnk_in, detected as vblnk_in = 1 while the registered vblnk_d = 0.
- Mouse latch: at each frame end, mouse_xpos/mouse_ypos are captured into mx/my. The captured values are used for the whole next frame.
- Obstacle-pixel test: obstacle_x ≠ 0 or obstacle_y ≠ 0. Pixel (0,0) is never a hit.
- Hit test, evaluated every cycle in PLAY: the pixel passes the obstacle-pixel test, and mx ≤ obstacle_x < mx + HITBOX_W, and my ≤ obstacle_y < my + HITBOX_H.
  - Both sums use 13-bit arithmetic; there is no wrap.
  - A hit sets the sticky hit flag.
- PLAY at frame end: a hit counts if the hit flag is set or the current cycle hits.
  - If it counts: hit_pulse = 1 and lives decrements.
  - If lives was 1, go to OVER with lives = 0.
  - Otherwise go to COOLDOWN and load the counter with COOLDOWN_FRAMES.
  - The hit flag is always cleared at frame end.
- COOLDOWN: invulnerable = 1. Hits are ignored and the flag is held clear.
  - Each frame end decrements the counter.
  - The frame end that takes the counter from 1 to 0 returns to PLAY.
  - Overlap during the first PLAY frame is evaluated normally.
- OVER: game_over = 1. lives holds 0 and hits are ignored.
- menu_on = 1 in any state forces IDLE on the next edge. It has priority over game_on, frame end and hit.
- At most one life is lost per frame, regardless of how many pixels hit.

## Timing
- Reset (rst = 0, asynchronous): state = IDLE, lives = LIVES, hit_pulse = 0, invulnerable = 0, game_over = 0, mx = my = 0, vblnk_d = 0, hit flag = 0, counter = 0.
- Reset release takes effect at the next pclk edge. Reset asserted mid-game aborts immediately with no hit_pulse.
- All outputs are registered.
- Frame end sampled at edge N gives lives / state / invulnerable / game_over / hit_pulse updates visible after edge N. hit_pulse is high for exactly the one cycle following edge N.
- An obstacle pixel presented at edge N is counted if it arrives no later than the frame-end edge.
- game_on sampled at edge N makes state = PLAY after edge N. Hits are counted from cycle N+1.
- vblnk_in held high does not retrigger frame end.

## Test plan
- Reset, no stimulus: lives = 3, hit_pulse/invulnerable/game_over = 0; mouse latch = 0.
- game_on, mouse (100,100) latched, frame with obstacle pixel at (105,110), then vblnk rise -> hit_pulse for one cycle, lives = 2, invulnerable = 1.
- Boundary, mouse (100,100), W=12, H=16:
  - pixels at (112,100) and (100,116) -> no hit.
  - (111,115) -> hit.
  - (0,0) with mouse at (0,0) -> no hit.
- Hits on every frame for COOLDOWN_FRAMES=2:
  - Frame 1 gives lives = 2.
  - Frames 2-3 are ignored.
  - invulnerable drops at frame 3's end.
  - Frame 4 gives lives = 1.
- Third counted hit -> lives = 0, game_over = 1; further hits are ignored; menu_on -> IDLE, lives = 3, game_over = 0 after one edge.
- Hit in the same frame where menu_on asserts at frame end -> IDLE, no hit_pulse, lives = 3; async rst mid-COOLDOWN -> immediate reset values.
